// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for the multi-cycle MIPS core. It sequences the shared
// datapath (one memory port, one ALU, IR, PC, register file) from the IR
// opcode and a memory-ready handshake. It also keeps cycle and
// retired-instruction counters so CPI can be checked.
//
// Ports:
//   CLK           clock, all state updates on the rising edge
//   Reset_L       synchronous active-low reset
//   opcode        IR[31:26]
//   mem_ready     memory access completes this cycle
//   PCWrite       unconditional PC write
//   PCWriteCond   PC write if branch condition met
//   BranchNE      1 = branch on ALU non-zero (bne), 0 = on zero (beq)
//   IorD          memory address select: 0 = PC, 1 = ALUOut
//   MemRead       memory read strobe
//   MemWrite      memory write strobe
//   IRWrite       load IR
//   MemtoReg      register write data: 1 = MDR, 0 = ALUOut
//   RegDst        destination register: 1 = rd, 0 = rt
//   RegWrite      register file write
//   ALUSrcA       0 = PC, 1 = rs
//   ALUSrcB       00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm << 2
//   ExtOp         1 = sign-extend, 0 = zero-extend
//   ALUOp         000 add, 001 sub, 010 funct, 011 or, 100 and, 101 slt, 110 lui
//   PCSource      00 = ALU, 01 = ALUOut, 10 = jump target
//   state         current state encoding
//   illegal       high in the ILLEGAL state
//   retire        pulse on the last cycle of each instruction
//   cycle_count   cycles since reset (saturating)
//   instr_count   instructions retired since reset (saturating)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // State encodings
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_RWB      = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_IEXEC    = 4'd10;
    localparam logic [3:0] S_IWB      = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // ALU operations
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0] state_q;
    logic [3:0] next_state;
    logic [3:0] dec_state;

    assign state = state_q;

    // State register
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state and output decode; while in reset the selects show FETCH
    // values and every strobe is forced low.
    always_comb begin
        next_state  = S_ILLEGAL;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        retire      = 1'b0;
        ExtOp       = !((opcode == OP_ANDI) || (opcode == OP_ORI));

        dec_state = Reset_L ? state_q : S_FETCH;

        case (dec_state)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:                  next_state = S_EXECUTE;
                    OP_LW, OP_SW:              next_state = S_MEMADDR;
                    OP_BEQ, OP_BNE:            next_state = S_BRANCH;
                    OP_J:                      next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_LUI:           next_state = S_IEXEC;
                    default:                   next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW) begin
                    next_state = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_ILLEGAL;
                end
            end
            S_MEMREAD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                retire     = mem_ready;
                next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_FUNCT;
                next_state = S_RWB;
            end
            S_RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (opcode == OP_BNE);
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    OP_SLTI: ALUOp = ALU_SLT;
                    OP_LUI:  ALUOp = ALU_LUI;
                    default: ALUOp = ALU_ADD;
                endcase
                next_state = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                next_state = S_ILLEGAL;
            end
            default: begin
                next_state = S_ILLEGAL;
            end
        endcase

        if (!Reset_L) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

    // Saturating performance counters; cycles stop counting once ILLEGAL
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if ((state_q != S_ILLEGAL) && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (retire && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        CLK;
    logic        Reset_L;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, illegal, retire;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic [31:0] cycle_count, instr_count;

    // Narrow-counter instance used to observe saturation
    logic        s_PCWrite, s_PCWriteCond, s_BranchNE, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
    logic        s_MemtoReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_ExtOp, s_illegal, s_retire;
    logic [1:0]  s_ALUSrcB, s_PCSource;
    logic [2:0]  s_ALUOp;
    logic [3:0]  s_state;
    logic [2:0]  s_cycle_count, s_instr_count;

    multicycle_control #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal(illegal), .retire(retire),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(3)) dut_sat (
        .CLK(CLK), .Reset_L(Reset_L), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .BranchNE(s_BranchNE),
        .IorD(s_IorD), .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
        .MemtoReg(s_MemtoReg), .RegDst(s_RegDst), .RegWrite(s_RegWrite),
        .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ExtOp(s_ExtOp), .ALUOp(s_ALUOp),
        .PCSource(s_PCSource), .state(s_state), .illegal(s_illegal), .retire(s_retire),
        .cycle_count(s_cycle_count), .instr_count(s_instr_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // stb: {PCWrite,PCWriteCond,MemRead,MemWrite,IRWrite,RegWrite,retire,illegal}
    // sel: {IorD,MemtoReg,RegDst,ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, BranchNE}
    typedef struct {
        logic        rst_l;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [7:0]  stb;
        logic [12:0] sel;
        int unsigned cyc;
        int unsigned ins;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic r, logic [5:0] o, logic m, logic [3:0] s,
                                logic [7:0] b, logic [12:0] l, int unsigned c, int unsigned i);
        vec_t v;
        v.rst_l = r; v.op = o; v.mr = m; v.st = s;
        v.stb = b; v.sel = l; v.cyc = c; v.ins = i;
        return v;
    endfunction

    function automatic logic [7:0] obs_stb();
        return {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, retire, illegal};
    endfunction

    function automatic logic [12:0] obs_sel();
        return {IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, BranchNE};
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, LUI = 6'b001111, BAD = 6'b111111;

    localparam logic [12:0] F1 = 13'b0000_01_1_000_00_0;  // FETCH, ExtOp 1
    localparam logic [12:0] F0 = 13'b0000_01_0_000_00_0;  // FETCH, ExtOp 0
    localparam logic [12:0] D1 = 13'b0000_11_1_000_00_0;  // DECODE, ExtOp 1
    localparam logic [12:0] D0 = 13'b0000_11_0_000_00_0;  // DECODE, ExtOp 0
    localparam logic [7:0]  FS = 8'b1010_1000;            // FETCH with mem_ready
    localparam logic [7:0]  WB = 8'b0000_0110;            // write-back + retire

    initial begin
        Reset_L = 1'b0; opcode = RT; mem_ready = 1'b1;

        // R-type with a one-cycle reset
        tbl.push_back(mk(0, RT, 1, 0, 8'h00, F1, 0, 0));
        tbl.push_back(mk(1, RT, 1, 0, FS, F1, 0, 0));
        tbl.push_back(mk(1, RT, 1, 1, 8'h00, D1, 1, 0));
        tbl.push_back(mk(1, RT, 1, 6, 8'h00, 13'b0001_00_1_010_00_0, 2, 0));
        tbl.push_back(mk(1, RT, 1, 7, WB, 13'b0010_00_1_000_00_0, 3, 0));
        // lw with two memory wait cycles
        tbl.push_back(mk(1, LW, 1, 0, FS, F1, 4, 1));
        tbl.push_back(mk(1, LW, 1, 1, 8'h00, D1, 5, 1));
        tbl.push_back(mk(1, LW, 1, 2, 8'h00, 13'b0001_10_1_000_00_0, 6, 1));
        tbl.push_back(mk(1, LW, 0, 3, 8'b0010_0000, 13'b1000_00_1_000_00_0, 7, 1));
        tbl.push_back(mk(1, LW, 0, 3, 8'b0010_0000, 13'b1000_00_1_000_00_0, 8, 1));
        tbl.push_back(mk(1, LW, 1, 3, 8'b0010_0000, 13'b1000_00_1_000_00_0, 9, 1));
        tbl.push_back(mk(1, LW, 1, 4, WB, 13'b0100_00_1_000_00_0, 10, 1));
        // beq then bne
        tbl.push_back(mk(1, BEQ, 1, 0, FS, F1, 11, 2));
        tbl.push_back(mk(1, BEQ, 1, 1, 8'h00, D1, 12, 2));
        tbl.push_back(mk(1, BEQ, 1, 8, 8'b0100_0010, 13'b0001_00_1_001_01_0, 13, 2));
        tbl.push_back(mk(1, BNE, 1, 0, FS, F1, 14, 3));
        tbl.push_back(mk(1, BNE, 1, 1, 8'h00, D1, 15, 3));
        tbl.push_back(mk(1, BNE, 1, 8, 8'b0100_0010, 13'b0001_00_1_001_01_1, 16, 3));
        // ori then addi
        tbl.push_back(mk(1, ORI, 1, 0, FS, F0, 17, 4));
        tbl.push_back(mk(1, ORI, 1, 1, 8'h00, D0, 18, 4));
        tbl.push_back(mk(1, ORI, 1, 10, 8'h00, 13'b0001_10_0_011_00_0, 19, 4));
        tbl.push_back(mk(1, ORI, 1, 11, WB, 13'b0000_00_0_000_00_0, 20, 4));
        tbl.push_back(mk(1, ADDI, 1, 0, FS, F1, 21, 5));
        tbl.push_back(mk(1, ADDI, 1, 1, 8'h00, D1, 22, 5));
        tbl.push_back(mk(1, ADDI, 1, 10, 8'h00, 13'b0001_10_1_000_00_0, 23, 5));
        tbl.push_back(mk(1, ADDI, 1, 11, WB, 13'b0000_00_1_000_00_0, 24, 5));
        // sw with one FETCH wait
        tbl.push_back(mk(1, SW, 0, 0, 8'b0010_0000, F1, 25, 6));
        tbl.push_back(mk(1, SW, 1, 0, FS, F1, 26, 6));
        tbl.push_back(mk(1, SW, 1, 1, 8'h00, D1, 27, 6));
        tbl.push_back(mk(1, SW, 1, 2, 8'h00, 13'b0001_10_1_000_00_0, 28, 6));
        tbl.push_back(mk(1, SW, 1, 5, 8'b0001_0010, 13'b1000_00_1_000_00_0, 29, 6));
        // j
        tbl.push_back(mk(1, JMP, 1, 0, FS, F1, 30, 7));
        tbl.push_back(mk(1, JMP, 1, 1, 8'h00, D1, 31, 7));
        tbl.push_back(mk(1, JMP, 1, 9, 8'b1000_0010, 13'b0000_00_1_000_10_0, 32, 7));
        // slti, andi, lui
        tbl.push_back(mk(1, SLTI, 1, 0, FS, F1, 33, 8));
        tbl.push_back(mk(1, SLTI, 1, 1, 8'h00, D1, 34, 8));
        tbl.push_back(mk(1, SLTI, 1, 10, 8'h00, 13'b0001_10_1_101_00_0, 35, 8));
        tbl.push_back(mk(1, SLTI, 1, 11, WB, 13'b0000_00_1_000_00_0, 36, 8));
        tbl.push_back(mk(1, ANDI, 1, 0, FS, F0, 37, 9));
        tbl.push_back(mk(1, ANDI, 1, 1, 8'h00, D0, 38, 9));
        tbl.push_back(mk(1, ANDI, 1, 10, 8'h00, 13'b0001_10_0_100_00_0, 39, 9));
        tbl.push_back(mk(1, ANDI, 1, 11, WB, 13'b0000_00_0_000_00_0, 40, 9));
        tbl.push_back(mk(1, LUI, 1, 0, FS, F1, 41, 10));
        tbl.push_back(mk(1, LUI, 1, 1, 8'h00, D1, 42, 10));
        tbl.push_back(mk(1, LUI, 1, 10, 8'h00, 13'b0001_10_1_110_00_0, 43, 10));
        tbl.push_back(mk(1, LUI, 1, 11, WB, 13'b0000_00_1_000_00_0, 44, 10));
        // illegal opcode
        tbl.push_back(mk(1, BAD, 1, 0, FS, F1, 45, 11));
        tbl.push_back(mk(1, BAD, 1, 1, 8'h00, D1, 46, 11));
        tbl.push_back(mk(1, BAD, 1, 12, 8'b0000_0001, 13'b0000_00_1_000_00_0, 47, 11));

        // Initial reset so state starts known
        repeat (2) @(negedge CLK);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            Reset_L = tbl[i].rst_l; opcode = tbl[i].op; mem_ready = tbl[i].mr;
            #1;
            chk("state", i, 32'(state), 32'(tbl[i].st));
            chk("strobes", i, 32'(obs_stb()), 32'(tbl[i].stb));
            chk("selects", i, 32'(obs_sel()), 32'(tbl[i].sel));
            chk("cycle_count", i, cycle_count, tbl[i].cyc);
            chk("instr_count", i, instr_count, tbl[i].ins);
            chk("sat_cycle_count", i, 32'(s_cycle_count), (tbl[i].cyc > 7) ? 32'd7 : tbl[i].cyc);
            chk("sat_instr_count", i, 32'(s_instr_count), (tbl[i].ins > 7) ? 32'd7 : tbl[i].ins);
        end

        // ILLEGAL is absorbing and freezes the cycle counter
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            mem_ready = 1'(i & 1);
            #1;
            chk("illegal_state", 100 + i, 32'(state), 32'd12);
            chk("illegal_strobes", 100 + i, 32'(obs_stb()), 32'h01);
            chk("illegal_cycle_count", 100 + i, cycle_count, 32'd47);
            chk("illegal_instr_count", 100 + i, instr_count, 32'd11);
        end

        // Reset exits ILLEGAL
        @(negedge CLK);
        Reset_L = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_strobes", 200, 32'(obs_stb()), 32'h00);
        chk("reset_selects", 200, 32'(obs_sel()), 32'(F1));
        @(negedge CLK);
        Reset_L = 1'b1; opcode = SW; mem_ready = 1'b1;
        #1;
        chk("post_reset_state", 201, 32'(state), 32'd0);
        chk("post_reset_cycle", 201, cycle_count, 32'd0);
        chk("post_reset_instr", 201, instr_count, 32'd0);
        chk("post_reset_sat_cycle", 201, 32'(s_cycle_count), 32'd0);
        chk("post_reset_strobes", 201, 32'(obs_stb()), 32'(FS));

        // Reset in the middle of a stalled sw
        @(negedge CLK); #1;
        chk("sw_decode", 202, 32'(state), 32'd1);
        @(negedge CLK); #1;
        chk("sw_memaddr", 203, 32'(state), 32'd2);
        @(negedge CLK);
        mem_ready = 1'b0;
        #1;
        chk("sw_wait_state", 204, 32'(state), 32'd5);
        chk("sw_wait_strobes", 204, 32'(obs_stb()), 32'b0001_0000);
        @(negedge CLK);
        Reset_L = 1'b0; mem_ready = 1'b0;
        #1;
        chk("sw_reset_state", 205, 32'(state), 32'd5);
        chk("sw_reset_strobes", 205, 32'(obs_stb()), 32'h00);
        @(negedge CLK);
        Reset_L = 1'b1; mem_ready = 1'b1;
        #1;
        chk("sw_abandon_state", 206, 32'(state), 32'd0);
        chk("sw_abandon_instr", 206, instr_count, 32'd0);
        chk("sw_abandon_cycle", 206, cycle_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
